riscv_multicycle_core: RTL

Parametrised multi-cycle successor to the single-cycle i16 core. It fetches 16-bit instructions over a req/ack handshake, executes them through a small state machine, and holds a register file of width `l` with r0 hardwired to zero. It adds conditional branches, jump-and-link, halt, and an optional iterative multiplier. It sits at the top of the CPU, between the instruction memory (now handshaked) and the debug observation bus.

---
 rtl/riscv_multicycle_core_if.sv | 12 +
 rtl/riscv_multicycle_core.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_core_if.sv
// Instruction fetch bus for riscv_multicycle_core: req/ack handshake with word address and 16-bit data.
interface riscv_multicycle_core_if #(
    parameter int unsigned l = 16
);
    logic         InstrReq;
    logic [l-1:0] InstrAddr;
    logic         InstrAck;
    logic [15:0]  InstrData;

    modport master (output InstrReq, InstrAddr, input InstrAck, InstrData);
    modport slave  (input InstrReq, InstrAddr, output InstrAck, InstrData);
endinterface

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle core executing 16-bit instructions over a handshaked fetch bus.
// Define RISCV_MUL_EN to build the iterative shift-add multiplier (MUL opcode); otherwise MUL is an illegal NOP.
module riscv_multicycle_core #(
    parameter int unsigned  l           = 16,
    parameter logic [l-1:0] ResetVector = '0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    riscv_multicycle_core_if.master bus,
    output logic                    Retire,
    output logic                    Halted,
    output logic                    IllegalOp,
    output logic [2:0]              Flags,
    output logic [8*l-1:0]          DebugData
);
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] HALT  = 2'd3;
`ifdef RISCV_MUL_EN
    localparam logic [1:0] MULT  = 2'd2;
    localparam int unsigned CntW = $clog2(l);
`endif

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpAddi = 3'b001;
    localparam logic [2:0] OpNand = 3'b010;
    localparam logic [2:0] OpLui  = 3'b011;
    localparam logic [2:0] OpMul  = 3'b100;
    localparam logic [2:0] OpBeq  = 3'b101;
    localparam logic [2:0] OpJalr = 3'b110;
    localparam logic [2:0] OpHalt = 3'b111;

    logic [1:0]   state;
    logic [l-1:0] pc;
    logic [15:0]  ir;
    logic [l-1:0] regs [8];

    logic [2:0]   op, ra, rb, rc;
    logic [l-1:0] valA, valB, valC, sImm, pcInc, pcNext, wbData;
    logic [l:0]   addSum;
    logic         wbEn, flagsEn, carryNext;

    assign op    = ir[15:13];
    assign ra    = ir[12:10];
    assign rb    = ir[9:7];
    assign rc    = ir[2:0];
    // regs[0] is reset to zero and never written, so r0 reads as 0 without a mux
    assign valA  = regs[ra];
    assign valB  = regs[rb];
    assign valC  = regs[rc];
    assign sImm  = {{(l-7){ir[6]}}, ir[6:0]};
    assign pcInc = pc + l'(1);
    assign addSum = {1'b0, valB} + {1'b0, (op == OpAddi) ? sImm : valC};

    assign bus.InstrReq  = (state == FETCH) && !Reset;
    assign bus.InstrAddr = pc;
    assign Halted        = (state == HALT);

    always_comb begin
        wbEn      = 1'b0;
        flagsEn   = 1'b0;
        carryNext = 1'b0;
        wbData    = '0;
        pcNext    = pcInc;
        case (op)
            OpAdd, OpAddi: begin
                wbEn      = 1'b1;
                flagsEn   = 1'b1;
                wbData    = addSum[l-1:0];
                carryNext = addSum[l];
            end
            OpNand: begin
                wbEn    = 1'b1;
                flagsEn = 1'b1;
                wbData  = ~(valB & valC);
            end
            OpLui: begin
                wbEn   = 1'b1;
                wbData = {ir[9:0], {(l-10){1'b0}}};
            end
            OpBeq: if (valA == valB) pcNext = pcInc + sImm;
            OpJalr: begin
                wbEn   = 1'b1;
                wbData = pcInc;
                pcNext = valB;
            end
            default: ;
        endcase
    end

`ifdef RISCV_MUL_EN
    logic [l-1:0]    mulAcc, mulCand, mulPlier, mulSum;
    logic [CntW-1:0] mulCnt;
    logic            mulLast;

    assign mulSum  = mulAcc + (mulPlier[0] ? mulCand : '0);
    assign mulLast = (state == MULT) && (mulCnt == CntW'(l - 1));
    assign Retire  = ((state == EXEC) && (op != OpHalt) && (op != OpMul)) || mulLast;
`else
    assign Retire  = (state == EXEC) && (op != OpHalt);
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= FETCH;
            pc        <= ResetVector;
            ir        <= '0;
            Flags     <= '0;
            IllegalOp <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
`ifdef RISCV_MUL_EN
            mulAcc   <= '0;
            mulCand  <= '0;
            mulPlier <= '0;
            mulCnt   <= '0;
`endif
        end else begin
            case (state)
                FETCH: if (bus.InstrAck) begin
                    ir    <= bus.InstrData;
                    state <= EXEC;
                end
                EXEC: begin
                    if (op == OpHalt) begin
                        state <= HALT;
`ifdef RISCV_MUL_EN
                    end else if (op == OpMul) begin
                        mulAcc   <= '0;
                        mulCand  <= valB;
                        mulPlier <= valC;
                        mulCnt   <= '0;
                        state    <= MULT;
`endif
                    end else begin
                        if (wbEn && (ra != 3'd0)) regs[ra] <= wbData;
                        if (flagsEn) Flags <= {carryNext, wbData[l-1], ~|wbData};
`ifndef RISCV_MUL_EN
                        if (op == OpMul) IllegalOp <= 1'b1;
`endif
                        pc    <= pcNext;
                        state <= FETCH;
                    end
                end
`ifdef RISCV_MUL_EN
                // Only the low l product bits are kept, so the shifted multiplicand may truncate.
                MULT: begin
                    mulAcc   <= mulSum;
                    mulCand  <= mulCand << 1;
                    mulPlier <= mulPlier >> 1;
                    mulCnt   <= mulCnt + CntW'(1);
                    if (mulLast) begin
                        if (ra != 3'd0) regs[ra] <= mulSum;
                        Flags <= {1'b0, mulSum[l-1], ~|mulSum};
                        pc    <= pcInc;
                        state <= FETCH;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) DebugData[l*i +: l] = regs[i];
    end
endmodule
